reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Write-port arbiter for the CPU register file: it shares the file's single write port (wen/waddr/wdata) between two writeback sources, channel 0 (ALU result) and channel 1 (memory load return). Each channel has a one-entry buffer behind a valid/ready handshake. A round-robin grant picks one buffered write per cycle and drives a registered write port. The block also exports a pending-write mask for hazard detection and a conflict counter for the performance-counter set.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width; file holds 2^ADDR_WIDTH registers
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- ch0_valid / ch1_valid  input  1  channel write request
- ch0_ready / ch1_ready  output  1  channel can accept this cycle (combinational)
- ch0_addr / ch1_addr  input  ADDR_WIDTH  destination register
- ch0_data / ch1_data  input  DATA_WIDTH  write data
- wb_wen  output  1  register file write enable (registered)
- wb_waddr  output  ADDR_WIDTH  register file write address (registered)
- wb_wdata  output  DATA_WIDTH  register file write data (registered)
- pending_mask  output  2^ADDR_WIDTH  bit r set while a write to r is buffered or on the output stage
- conflict_cnt  output  32  count of cycles in which both buffers were valid

## Operation
- Per channel i: buffer buf_i (valid, addr, data). Transfer occurs when chi_valid && chi_ready; buffer captures addr/data at that edge.
- chi_ready = !buf_i.valid || gnt_i. A granted buffer drains and refills on the same edge, so one channel alone sustains one write per cycle.
- Grant (combinational, from buffer state): if only one buffer is valid, grant it. If both are valid, grant the channel != last_grant. If neither is valid, no grant.
- On the edge following a grant:
  - Granted buffer clears, unless it refills in the same cycle.
  - last_grant <= granted channel.
  - wb_waddr/wb_wdata <= granted buffer's addr/data.
  - wb_wen <= 1 if addr != 0; wb_wen <= 0 if addr == 0. Register 0 writes are consumed and dropped.
- No grant: wb_wen <= 0; wb_waddr/wb_wdata hold their previous values.
- pending_mask = OR of decoded buf_0.addr (if valid), buf_1.addr (if valid), and wb_waddr (if wb_wen). Bit 0 is always 0.
- conflict_cnt increments by 1 each cycle both buffers are valid. Wraps modulo 2^32.
- Same-address writes from both channels: the writes issue in grant order, and the last granted write wins in the file.

## Timing
- Reset (rst=1 at edge): buf_0/buf_1 invalid; last_grant=1, so channel 0 wins the first tie; wb_wen=0, wb_waddr=0, wb_wdata=0; conflict_cnt=0. With buffers empty after reset, pending_mask=0 and ch0_ready=ch1_ready=1.
- Reset mid-operation discards buffered and in-flight writes. No write reaches the file after the reset edge.
- Latency: handshake at edge N → buffered → granted in cycle N+1 → wb_wen high in cycle N+2 (two cycles from accept to file write, uncontended).
- Contention: the loser stalls one cycle per winning write. With both channels streaming, grants alternate 0,1,0,1. Neither channel waits more than one grant.
- ready must not depend on the same cycle's chi_valid (no combinational loop). The valid/addr/data inputs must be held stable while valid=1 and ready=0.

## Test plan
- Reset: drive rst for 2 cycles with both channels valid → wb_wen=0, pending_mask=0, conflict_cnt=0, both ready=1 after release.
- Single channel stream: ch0 sends (r3,0x11),(r4,0x22),(r5,0x33) on consecutive cycles → wb_wen high for 3 consecutive cycles starting 2 cycles after first accept, in order; ch0_ready stays 1.
- Tie/round-robin: both channels valid every cycle, ch0 → r1..r4, ch1 → r8..r11 → output order r1,r8,r2,r9,…; ready toggles alternately; conflict_cnt increments each cycle both buffers are full.
- Register zero: ch1 writes (r0,0xDEAD) → consumed (ch1_ready returns 1), wb_wen stays 0, pending_mask bit 0 never set.
- Pending mask: ch0 writes r7 while ch1 buffer holds r9 and is stalled → pending_mask=0x280 until the drains complete, then 0.
- Mid-operation reset: assert rst while both buffers are full → next cycle wb_wen=0; no write to those addresses occurs afterward.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Shares the register-file write port between ALU (ch0) and load-return (ch1) writebacks.
// Accept-to-write latency 2 cycles; each channel has a one-entry buffer and stalls only while its buffer loses arbitration.
module reg_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ch0_valid,
   output logic                         ch0_ready,
   input  logic [ADDR_WIDTH-1:0]        ch0_addr,
   input  logic [DATA_WIDTH-1:0]        ch0_data,
   input  logic                         ch1_valid,
   output logic                         ch1_ready,
   input  logic [ADDR_WIDTH-1:0]        ch1_addr,
   input  logic [DATA_WIDTH-1:0]        ch1_data,
   output logic                         wb_wen,
   output logic [ADDR_WIDTH-1:0]        wb_waddr,
   output logic [DATA_WIDTH-1:0]        wb_wdata,
   output logic [(1<<ADDR_WIDTH)-1:0]   pending_mask,
   output logic [31:0]                  conflict_cnt
);

   logic                  buf0_valid, buf1_valid;
   logic [ADDR_WIDTH-1:0] buf0_addr, buf1_addr;
   logic [DATA_WIDTH-1:0] buf0_data, buf1_data;
   logic                  last_grant;
   logic                  gnt0, gnt1;

   // On a tie the channel that did not win last time goes next.
   always_comb begin
      gnt0 = buf0_valid && (!buf1_valid || last_grant);
      gnt1 = buf1_valid && (!buf0_valid || !last_grant);
   end

   assign ch0_ready = !buf0_valid || gnt0;
   assign ch1_ready = !buf1_valid || gnt1;

   always_ff @(posedge clk) begin
      if (rst) begin
         buf0_valid <= 1'b0;
         buf0_addr  <= '0;
         buf0_data  <= '0;
         buf1_valid <= 1'b0;
         buf1_addr  <= '0;
         buf1_data  <= '0;
      end else begin
         if (ch0_valid && ch0_ready) begin
            buf0_valid <= 1'b1;
            buf0_addr  <= ch0_addr;
            buf0_data  <= ch0_data;
         end else if (gnt0) begin
            buf0_valid <= 1'b0;
         end
         if (ch1_valid && ch1_ready) begin
            buf1_valid <= 1'b1;
            buf1_addr  <= ch1_addr;
            buf1_data  <= ch1_data;
         end else if (gnt1) begin
            buf1_valid <= 1'b0;
         end
      end
   end

   // Register 0 writes drain through the stage but never assert the enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         wb_wen     <= 1'b0;
         wb_waddr   <= '0;
         wb_wdata   <= '0;
      end else if (gnt0) begin
         last_grant <= 1'b0;
         wb_wen     <= (buf0_addr != '0);
         wb_waddr   <= buf0_addr;
         wb_wdata   <= buf0_data;
      end else if (gnt1) begin
         last_grant <= 1'b1;
         wb_wen     <= (buf1_addr != '0);
         wb_waddr   <= buf1_addr;
         wb_wdata   <= buf1_data;
      end else begin
         wb_wen     <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (buf0_valid && buf1_valid) begin
         conflict_cnt <= conflict_cnt + 32'd1;
      end
   end

   always_comb begin
      pending_mask = '0;
      if (buf0_valid) pending_mask[buf0_addr] = 1'b1;
      if (buf1_valid) pending_mask[buf1_addr] = 1'b1;
      if (wb_wen)     pending_mask[wb_waddr]  = 1'b1;
      pending_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed vector bench for reg_wb_arbiter; each record gives inputs for one cycle and the outputs expected just after that edge.
module tb_reg_wb_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          ch0_valid, ch1_valid;
   logic          ch0_ready, ch1_ready;
   logic [AW-1:0] ch0_addr, ch1_addr;
   logic [DW-1:0] ch0_data, ch1_data;
   logic          wb_wen;
   logic [AW-1:0] wb_waddr;
   logic [DW-1:0] wb_wdata;
   logic [31:0]   pending_mask;
   logic [31:0]   conflict_cnt;

   always #5 clk = ~clk;

   reg_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .ch0_valid(ch0_valid), .ch0_ready(ch0_ready), .ch0_addr(ch0_addr), .ch0_data(ch0_data),
      .ch1_valid(ch1_valid), .ch1_ready(ch1_ready), .ch1_addr(ch1_addr), .ch1_data(ch1_data),
      .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .pending_mask(pending_mask), .conflict_cnt(conflict_cnt)
   );

   typedef struct {
      logic          rst;
      logic          v0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          v1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          r0;
      logic          r1;
      logic          wen;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [31:0]   mask;
      logic [31:0]   cnt;
   } vec_t;

   vec_t vq[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic void add(input int rst_i, input int v0, input int a0, input int d0,
                               input int v1, input int a1, input int d1,
                               input int r0, input int r1, input int wen, input int wa,
                               input int wd, input int mask, input int cnt);
      vec_t v;
      v.rst = rst_i[0]; v.v0 = v0[0]; v.a0 = a0[AW-1:0]; v.d0 = d0;
      v.v1 = v1[0]; v.a1 = a1[AW-1:0]; v.d1 = d1;
      v.r0 = r0[0]; v.r1 = r1[0]; v.wen = wen[0]; v.wa = wa[AW-1:0];
      v.wd = wd; v.mask = mask; v.cnt = cnt;
      vq.push_back(v);
   endfunction

   task automatic check(input string name, input logic r0, input logic r1, input logic wen,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [31:0] mask, input logic [31:0] cnt);
      vectors++;
      if ({ch0_ready, ch1_ready, wb_wen, wb_waddr, wb_wdata, pending_mask, conflict_cnt} !==
          {r0, r1, wen, wa, wd, mask, cnt}) begin
         miscompares++;
         $display("FAIL %s: got rdy=%b%b wen=%b waddr=%0d wdata=%h mask=%h cnt=%0d; expected rdy=%b%b wen=%b waddr=%0d wdata=%h mask=%h cnt=%0d",
                  name, ch0_ready, ch1_ready, wb_wen, wb_waddr, wb_wdata, pending_mask, conflict_cnt,
                  r0, r1, wen, wa, wd, mask, cnt);
      end
   endtask

   initial begin
      int  lat;
      bit  found;

      rst = 1'b1;
      ch0_valid = 1'b0; ch0_addr = '0; ch0_data = '0;
      ch1_valid = 1'b0; ch1_addr = '0; ch1_data = '0;

      //  rst v0 a0 d0        v1 a1 d1          r0 r1 wen wa wd        mask     cnt
      // reset with both channels requesting
      add(1, 1, 3, 'hA0,   1, 4, 'hB0,     1, 1, 0, 0,  0,        'h0,     0);
      add(1, 1, 3, 'hA0,   1, 4, 'hB0,     1, 1, 0, 0,  0,        'h0,     0);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 0, 0,  0,        'h0,     0);
      // ch0 alone, back-to-back
      add(0, 1, 3, 'h11,   0, 0, 0,        1, 1, 0, 0,  0,        'h8,     0);
      add(0, 1, 4, 'h22,   0, 0, 0,        1, 1, 1, 3,  'h11,     'h18,    0);
      add(0, 1, 5, 'h33,   0, 0, 0,        1, 1, 1, 4,  'h22,     'h30,    0);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 1, 5,  'h33,     'h20,    0);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 0, 5,  'h33,     'h0,     0);
      add(1, 0, 0, 0,      0, 0, 0,        1, 1, 0, 0,  0,        'h0,     0);
      // both streaming; inputs held while not ready
      add(0, 1, 1, 'h101,  1, 8, 'h208,    1, 0, 0, 0,  0,        'h102,   0);
      add(0, 1, 2, 'h102,  1, 9, 'h209,    0, 1, 1, 1,  'h101,    'h106,   1);
      add(0, 1, 3, 'h103,  1, 9, 'h209,    1, 0, 1, 8,  'h208,    'h304,   2);
      add(0, 1, 3, 'h103,  1, 10, 'h20A,   0, 1, 1, 2,  'h102,    'h20C,   3);
      add(0, 1, 4, 'h104,  1, 10, 'h20A,   1, 0, 1, 9,  'h209,    'h608,   4);
      add(0, 1, 4, 'h104,  1, 11, 'h20B,   0, 1, 1, 3,  'h103,    'h418,   5);
      add(0, 0, 0, 0,      1, 11, 'h20B,   1, 0, 1, 10, 'h20A,    'hC10,   6);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 1, 4,  'h104,    'h810,   7);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 1, 11, 'h20B,    'h800,   7);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 0, 11, 'h20B,    'h0,     7);
      // register zero is consumed without a write
      add(0, 0, 0, 0,      1, 0, 'hDEAD,   1, 1, 0, 11, 'h20B,    'h0,     7);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 0, 0,  'hDEAD,   'h0,     7);
      // ch1 stalled behind ch0
      add(0, 1, 7, 'h77,   1, 9, 'h99,     1, 0, 0, 0,  'hDEAD,   'h280,   7);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 1, 7,  'h77,     'h280,   8);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 1, 9,  'h99,     'h200,   8);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 0, 9,  'h99,     'h0,     8);
      // reset with both buffers full
      add(0, 1, 5, 'h55,   1, 6, 'h66,     1, 0, 0, 9,  'h99,     'h60,    8);
      add(1, 0, 0, 0,      0, 0, 0,        1, 1, 0, 0,  0,        'h0,     0);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 0, 0,  0,        'h0,     0);
      add(0, 0, 0, 0,      0, 0, 0,        1, 1, 0, 0,  0,        'h0,     0);

      foreach (vq[i]) begin
         @(negedge clk);
         rst       = vq[i].rst;
         ch0_valid = vq[i].v0; ch0_addr = vq[i].a0; ch0_data = vq[i].d0;
         ch1_valid = vq[i].v1; ch1_addr = vq[i].a1; ch1_data = vq[i].d1;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vq[i].r0, vq[i].r1, vq[i].wen, vq[i].wa,
               vq[i].wd, vq[i].mask, vq[i].cnt);
      end

      // accept-to-write latency on ch1, bounded wait
      @(negedge clk);
      rst = 1'b0;
      ch0_valid = 1'b0;
      ch1_valid = 1'b1; ch1_addr = 5'd12; ch1_data = 32'hC0DE;
      lat = 0;
      found = 1'b0;
      for (int k = 0; k < 6 && !found; k++) begin
         @(posedge clk);
         #1;
         lat++;
         ch1_valid = 1'b0;
         if (wb_wen) found = 1'b1;
      end
      vectors++;
      if (!found || lat != 2) begin
         miscompares++;
         $display("FAIL latency: got %0d edges (seen=%0d), expected 2", lat, found);
      end
      check("lat_out", 1'b1, 1'b1, 1'b1, 5'd12, 32'hC0DE, 32'h1000, 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("lat_idle", 1'b1, 1'b1, 1'b0, 5'd12, 32'hC0DE, 32'h0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
